// File: rtl/data_sram_ctrl.sv
// rtl/data_sram_ctrl.sv - MEM-stage load/store sequencer for a req/addr_ok/data_ok SRAM data port
module data_sram_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_req,
    input  logic        ex_we,
    input  logic [1:0]  ex_size,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic        wb_ready,
    output logic        stallreq,
    output logic [31:0] mem_rdata,
    output logic        mem_rdata_valid,
    output logic        align_err,
    output logic        timeout_err,
    output logic        data_sram_req,
    output logic        data_sram_wr,
    output logic [1:0]  data_sram_size,
    output logic [31:0] data_sram_addr,
    output logic [3:0]  data_sram_wstrb,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata
);

    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10,
        S_DONE = 2'b11
    } state_t;

    state_t      state;
    logic [7:0]  tmo_cnt;
    logic        req_q;
    logic        misaligned;
    logic        can_accept;
    logic        accept;
    logic [3:0]  strb_next;
    logic [31:0] wdata_next;

    // Alignment rule: halves need addr[0]==0, words (and size 11) need addr[1:0]==0
    always_comb begin
        misaligned = 1'b0;
        case (ex_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = ex_addr[0];
            default: misaligned = (ex_addr[1:0] != 2'b00);
        endcase
    end

    // Byte-lane strobes and lane-replicated write data for the incoming op
    always_comb begin
        strb_next  = 4'b0000;
        wdata_next = ex_wdata;
        case (ex_size)
            2'b00: begin
                wdata_next = {4{ex_wdata[7:0]}};
                if (ex_we) begin
                    strb_next = 4'b0001 << ex_addr[1:0];
                end
            end
            2'b01: begin
                wdata_next = {2{ex_wdata[15:0]}};
                if (ex_we) begin
                    strb_next = ex_addr[1] ? 4'b1100 : 4'b0011;
                end
            end
            default: begin
                wdata_next = ex_wdata;
                if (ex_we) begin
                    strb_next = 4'b1111;
                end
            end
        endcase
    end

    // Accept window, stall request and status outputs; all forced low while rst is high
    always_comb begin
        can_accept      = (state == S_IDLE) || ((state == S_DONE) && wb_ready);
        accept          = can_accept && ex_req && !misaligned;
        align_err       = !rst && can_accept && ex_req && misaligned;
        stallreq        = !rst && (((state == S_IDLE) && accept) ||
                                   (state == S_REQ) || (state == S_WAIT));
        data_sram_req   = !rst && req_q;
        mem_rdata_valid = !rst && (state == S_DONE);
        timeout_err     = !rst && ((state == S_REQ) || (state == S_WAIT)) &&
                          (tmo_cnt == TMO_LIMIT);
    end

    // Access sequencer: latches the request, drives the handshake, captures load data
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            req_q           <= 1'b0;
            tmo_cnt         <= 8'd0;
            mem_rdata       <= 32'd0;
            data_sram_wr    <= 1'b0;
            data_sram_size  <= 2'b00;
            data_sram_addr  <= 32'd0;
            data_sram_wstrb <= 4'b0000;
            data_sram_wdata <= 32'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        state           <= S_REQ;
                        req_q           <= 1'b1;
                        tmo_cnt         <= 8'd0;
                        data_sram_wr    <= ex_we;
                        data_sram_size  <= ex_size;
                        data_sram_addr  <= ex_addr;
                        data_sram_wstrb <= strb_next;
                        data_sram_wdata <= wdata_next;
                    end else if (state == S_DONE && wb_ready) begin
                        state <= S_IDLE;
                    end
                end
                S_REQ: begin
                    if (tmo_cnt != TMO_LIMIT) begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                    if (data_sram_addr_ok) begin
                        req_q <= 1'b0;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (tmo_cnt != TMO_LIMIT) begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                    if (data_sram_data_ok) begin
                        if (!data_sram_wr) begin
                            mem_rdata <= data_sram_rdata;
                        end
                        state <= S_DONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_sram_ctrl.sv
// tb/tb_data_sram_ctrl.sv - scoreboard bench for data_sram_ctrl
module tb_data_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_req;
    logic        ex_we;
    logic [1:0]  ex_size;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic        wb_ready;
    logic        stallreq;
    logic [31:0] mem_rdata;
    logic        mem_rdata_valid;
    logic        align_err;
    logic        timeout_err;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    always #5 clk = ~clk;

    data_sram_ctrl #(.TIMEOUT(8)) dut (
        .clk               (clk),
        .rst               (rst),
        .ex_req            (ex_req),
        .ex_we             (ex_we),
        .ex_size           (ex_size),
        .ex_addr           (ex_addr),
        .ex_wdata          (ex_wdata),
        .wb_ready          (wb_ready),
        .stallreq          (stallreq),
        .mem_rdata         (mem_rdata),
        .mem_rdata_valid   (mem_rdata_valid),
        .align_err         (align_err),
        .timeout_err       (timeout_err),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata)
    );

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } req_t;

    req_t        req_exp[$];
    logic [31:0] cpl_exp[$];
    logic [31:0] align_exp[$];
    req_t        mon_r;
    logic [31:0] mon_w;
    logic [31:0] cur_addr;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expected SRAM requests, completions and alignment errors as the DUT presents them
    always @(negedge clk) begin
        if (data_sram_req && data_sram_addr_ok) begin
            if (req_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL req_unexpected: got request at 0x%08h, expected none", data_sram_addr);
            end else begin
                mon_r = req_exp.pop_front();
                chk("req_wr",    32'(data_sram_wr),    32'(mon_r.wr));
                chk("req_size",  32'(data_sram_size),  32'(mon_r.size));
                chk("req_addr",  data_sram_addr,       mon_r.addr);
                chk("req_wstrb", 32'(data_sram_wstrb), 32'(mon_r.strb));
                chk("req_wdata", data_sram_wdata,      mon_r.wdata);
            end
        end
        if (mem_rdata_valid && wb_ready) begin
            if (cpl_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cpl_unexpected: got completion 0x%08h, expected none", mem_rdata);
            end else begin
                mon_w = cpl_exp.pop_front();
                chk("cpl_rdata", mem_rdata, mon_w);
            end
        end
        if (align_err) begin
            if (align_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL align_unexpected: got align_err at 0x%08h, expected none", ex_addr);
            end else begin
                mon_w = align_exp.pop_front();
                chk("align_addr", ex_addr, mon_w);
            end
        end
    end

    // mode 0: expect request and completion; 1: request only; 2: neither
    task automatic issue(input logic we, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] e_strb,
                         input logic [31:0] e_wdata, input logic [31:0] e_rdata,
                         input logic e_stall, input int mode);
        req_t r;
        r.wr = we; r.size = size; r.addr = addr; r.strb = e_strb; r.wdata = e_wdata;
        ex_req = 1'b1; ex_we = we; ex_size = size; ex_addr = addr; ex_wdata = wdata;
        cur_addr = addr;
        if (mode <= 1) req_exp.push_back(r);
        if (mode == 0) cpl_exp.push_back(e_rdata);
        @(negedge clk);
        chk("issue_stall", 32'(stallreq), 32'(e_stall));
        chk("issue_align", 32'(align_err), 32'd0);
        cyc();
        ex_req = 1'b0; ex_we = ~we; ex_addr = ~addr; ex_wdata = ~wdata;
    endtask

    task automatic run_req(input int a_lat);
        for (int i = 0; i < a_lat; i++) begin
            ex_req = 1'b1;
            data_sram_addr_ok = 1'b0;
            data_sram_data_ok = 1'b1;
            data_sram_rdata   = 32'hBAD0BAD0;
            @(negedge clk);
            chk("req_held",    32'(data_sram_req), 32'd1);
            chk("req_stall",   32'(stallreq),      32'd1);
            chk("addr_stable", data_sram_addr,     cur_addr);
            cyc();
        end
        data_sram_data_ok = 1'b0;
        data_sram_addr_ok = 1'b1;
        @(negedge clk);
        chk("req_accept", 32'(data_sram_req), 32'd1);
        cyc();
        data_sram_addr_ok = 1'b0;
    endtask

    task automatic run_wait(input int d_lat, input logic [31:0] rdata);
        for (int i = 0; i < d_lat - 1; i++) begin
            @(negedge clk);
            chk("wait_req",   32'(data_sram_req),   32'd0);
            chk("wait_stall", 32'(stallreq),        32'd1);
            chk("wait_valid", 32'(mem_rdata_valid), 32'd0);
            cyc();
        end
        ex_req = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = rdata;
        @(negedge clk);
        chk("dok_req",   32'(data_sram_req), 32'd0);
        chk("dok_stall", 32'(stallreq),      32'd1);
        cyc();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h5A5A5A5A;
    endtask

    task automatic finish_acc(input int hold, input logic [31:0] e_rdata);
        for (int i = 0; i < hold; i++) begin
            wb_ready = 1'b0;
            ex_req   = 1'b1;
            @(negedge clk);
            chk("hold_valid", 32'(mem_rdata_valid), 32'd1);
            chk("hold_rdata", mem_rdata,            e_rdata);
            chk("hold_stall", 32'(stallreq),        32'd0);
            chk("hold_noreq", 32'(data_sram_req),   32'd0);
            cyc();
        end
        ex_req   = 1'b0;
        wb_ready = 1'b1;
        @(negedge clk);
        chk("done_valid", 32'(mem_rdata_valid), 32'd1);
        chk("done_stall", 32'(stallreq),        32'd0);
        cyc();
        @(negedge clk);
        chk("idle_valid", 32'(mem_rdata_valid), 32'd0);
        chk("idle_req",   32'(data_sram_req),   32'd0);
        cyc();
    endtask

    task automatic misalign(input logic we, input logic [1:0] size, input logic [31:0] addr);
        ex_req = 1'b1; ex_we = we; ex_size = size; ex_addr = addr; ex_wdata = 32'h12345678;
        align_exp.push_back(addr);
        @(negedge clk);
        chk("mis_pulse", 32'(align_err),     32'd1);
        chk("mis_stall", 32'(stallreq),      32'd0);
        chk("mis_req",   32'(data_sram_req), 32'd0);
        cyc();
        ex_req = 1'b0;
        @(negedge clk);
        chk("mis_clear", 32'(align_err),     32'd0);
        chk("mis_noreq", 32'(data_sram_req), 32'd0);
        cyc();
    endtask

    // Watchdog bound on the whole run
    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, expected summary before time limit");
        $fatal(1);
    end

    // Directed stimulus
    initial begin
        rst = 1'b1; ex_req = 1'b0; ex_we = 1'b0; ex_size = 2'b00; ex_addr = 32'd0;
        ex_wdata = 32'd0; wb_ready = 1'b1; data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b0; data_sram_rdata = 32'd0; cur_addr = 32'd0;
        cyc();
        cyc();
        @(negedge clk);
        chk("rst_req",     32'(data_sram_req),   32'd0);
        chk("rst_stall",   32'(stallreq),        32'd0);
        chk("rst_valid",   32'(mem_rdata_valid), 32'd0);
        chk("rst_rdata",   mem_rdata,            32'd0);
        chk("rst_timeout", 32'(timeout_err),     32'd0);
        chk("rst_wstrb",   32'(data_sram_wstrb), 32'd0);
        chk("rst_addr",    data_sram_addr,       32'd0);
        cyc();
        rst = 1'b0;
        cyc();

        // sw 0x1000: addr_ok cycle 1, data_ok cycle 2, valid cycle 3
        issue(1'b1, 2'b10, 32'h1000, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b1, 0);
        run_req(0);
        run_wait(1, 32'hEEEEEEEE);
        finish_acc(0, 32'h0);

        // Sub-word stores and size 11 treated as word
        issue(1'b1, 2'b00, 32'h1003, 32'h000000A5, 4'b1000, 32'hA5A5A5A5, 32'h0, 1'b1, 0);
        run_req(0); run_wait(1, 32'hEEEEEEEE); finish_acc(0, 32'h0);
        issue(1'b1, 2'b01, 32'h1002, 32'h00001234, 4'b1100, 32'h12341234, 32'h0, 1'b1, 0);
        run_req(1); run_wait(1, 32'hEEEEEEEE); finish_acc(0, 32'h0);
        issue(1'b1, 2'b00, 32'h1001, 32'hFFFFFF7C, 4'b0010, 32'h7C7C7C7C, 32'h0, 1'b1, 0);
        run_req(0); run_wait(2, 32'hEEEEEEEE); finish_acc(0, 32'h0);
        issue(1'b1, 2'b11, 32'h4000, 32'h0BADF00D, 4'b1111, 32'h0BADF00D, 32'h0, 1'b1, 0);
        run_req(0); run_wait(1, 32'hEEEEEEEE); finish_acc(0, 32'h0);

        // lh 0x2002: addr_ok 3 late, data_ok 2 after, wb_ready low 4 cycles
        issue(1'b0, 2'b01, 32'h2002, 32'h0, 4'b0000, 32'h0, 32'h80011234, 1'b1, 0);
        run_req(3); run_wait(2, 32'h80011234); finish_acc(4, 32'h80011234);
        // Store after load keeps the old read word
        issue(1'b1, 2'b10, 32'h3000, 32'h11223344, 4'b1111, 32'h11223344, 32'h80011234, 1'b1, 0);
        run_req(0); run_wait(1, 32'hEEEEEEEE); finish_acc(1, 32'h80011234);
        issue(1'b0, 2'b00, 32'h2003, 32'h0, 4'b0000, 32'h0, 32'hF7665544, 1'b1, 0);
        run_req(0); run_wait(1, 32'hF7665544); finish_acc(0, 32'hF7665544);

        // Misaligned requests are dropped
        misalign(1'b0, 2'b10, 32'h2001);
        misalign(1'b0, 2'b01, 32'h2003);
        misalign(1'b1, 2'b10, 32'h2002);
        misalign(1'b1, 2'b11, 32'h2002);

        // Timeout with TIMEOUT=8: REQ entered cycle 1, error from cycle 9
        issue(1'b1, 2'b10, 32'h5000, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D, 32'hF7665544, 1'b1, 0);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk("tmo_low", 32'(timeout_err),   32'd0);
            chk("tmo_req", 32'(data_sram_req), 32'd1);
            cyc();
        end
        @(negedge clk);
        chk("tmo_rise",    32'(timeout_err),   32'd1);
        chk("tmo_req_hold", 32'(data_sram_req), 32'd1);
        cyc();
        @(negedge clk);
        chk("tmo_sat", 32'(timeout_err), 32'd1);
        cyc();
        data_sram_addr_ok = 1'b1;
        @(negedge clk);
        chk("tmo_aok", 32'(timeout_err), 32'd1);
        cyc();
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hEEEEEEEE;
        @(negedge clk);
        chk("tmo_wait", 32'(timeout_err), 32'd1);
        cyc();
        data_sram_data_ok = 1'b0;
        @(negedge clk);
        chk("tmo_done_clear", 32'(timeout_err),     32'd0);
        chk("tmo_done_valid", 32'(mem_rdata_valid), 32'd1);
        cyc();
        @(negedge clk);
        chk("tmo_idle", 32'(mem_rdata_valid), 32'd0);
        cyc();

        // Reset during REQ: request drops in the reset cycle
        issue(1'b0, 2'b10, 32'h6000, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 2);
        rst = 1'b1;
        @(negedge clk);
        chk("rstreq_req",   32'(data_sram_req), 32'd0);
        chk("rstreq_stall", 32'(stallreq),      32'd0);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rstreq_rdata", mem_rdata,            32'd0);
        chk("rstreq_valid", 32'(mem_rdata_valid), 32'd0);
        chk("rstreq_idle",  32'(data_sram_req),   32'd0);
        cyc();

        // Reset during WAIT, late data_ok ignored
        issue(1'b0, 2'b10, 32'h6004, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 1);
        run_req(0);
        rst = 1'b1;
        @(negedge clk);
        chk("rstwait_stall", 32'(stallreq), 32'd0);
        cyc();
        rst = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h11111111;
        @(negedge clk);
        chk("late_valid", 32'(mem_rdata_valid), 32'd0);
        chk("late_req",   32'(data_sram_req),   32'd0);
        cyc();
        data_sram_data_ok = 1'b0;
        @(negedge clk);
        chk("late_rdata", mem_rdata,            32'd0);
        chk("late_valid2", 32'(mem_rdata_valid), 32'd0);
        cyc();

        // Back-to-back: new lw accepted in DONE with wb_ready
        issue(1'b0, 2'b10, 32'h7000, 32'h0, 4'b0000, 32'h0, 32'hA1B2C3D4, 1'b1, 0);
        run_req(0);
        run_wait(1, 32'hA1B2C3D4);
        issue(1'b0, 2'b10, 32'h7004, 32'h0, 4'b0000, 32'h0, 32'h0F0F0F0F, 1'b0, 0);
        run_req(0);
        run_wait(1, 32'h0F0F0F0F);
        finish_acc(0, 32'h0F0F0F0F);

        chk("req_queue_empty",   32'(req_exp.size()),   32'd0);
        chk("cpl_queue_empty",   32'(cpl_exp.size()),   32'd0);
        chk("align_queue_empty", 32'(align_exp.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
